// File: rtl/ravenoc_wh_arbiter_if.sv
// Handshake bundle between the RaveNoC input ports and one wormhole output-port arbiter.
// The master side drives requests; the slave side is the arbiter.
interface ravenoc_wh_arbiter_if #(
  parameter int N_INPUTS = 4,
  parameter int IDX_W    = $clog2(N_INPUTS)
);
  logic [N_INPUTS-1:0]   req_i;
  logic [2*N_INPUTS-1:0] flit_type_i;
  logic                  out_ready_i;
  logic [N_INPUTS-1:0]   grant_o;
  logic [IDX_W-1:0]      sel_o;
  logic                  valid_o;
  logic                  locked_o;
  logic                  err_o;

  modport master (
    output req_i, flit_type_i, out_ready_i,
    input  grant_o, sel_o, valid_o, locked_o, err_o
  );

  modport slave (
    input  req_i, flit_type_i, out_ready_i,
    output grant_o, sel_o, valid_o, locked_o, err_o
  );
endinterface

// File: rtl/ravenoc_wh_arbiter.sv
// Wormhole output-port arbiter: round-robin among head flits, grant locked
// from head to tail so packets never interleave on the output port.
module ravenoc_wh_arbiter #(
  parameter int N_INPUTS = 4,
  parameter int IDX_W    = $clog2(N_INPUTS)
) (
  input logic                 clk,
  input logic                 arst,
  ravenoc_wh_arbiter_if.slave bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [1:0] HEAD      = 2'd0;
  localparam logic [1:0] BODY      = 2'd1;
  localparam logic [1:0] TAIL      = 2'd2;
  localparam logic [1:0] HEAD_TAIL = 2'd3;

  state_t              state, next_state;
  logic [IDX_W-1:0]    owner, next_owner;
  logic [IDX_W-1:0]    rr_ptr, next_rr;
  logic [IDX_W-1:0]    winner, sel, scan_idx;
  logic [IDX_W:0]      scan_sum;
  logic [1:0]          owner_type, scan_type;
  logic                found, err_q, next_err;
  logic [N_INPUTS-1:0] grant;

  function automatic logic [1:0] type_of(input logic [2*N_INPUTS-1:0] ft,
                                         input logic [IDX_W-1:0] k);
    return ft[{k, 1'b0} +: 2];
  endfunction

  function automatic logic [IDX_W-1:0] incr(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_INPUTS - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= next_state;
      owner  <= next_owner;
      rr_ptr <= next_rr;
      err_q  <= next_err;
    end
  end

  always_comb begin
    next_state = state;
    next_owner = owner;
    next_rr    = rr_ptr;
    next_err   = 1'b0;
    grant      = '0;
    sel        = rr_ptr;
    winner     = rr_ptr;
    found      = 1'b0;
    scan_sum   = '0;
    scan_idx   = '0;
    scan_type  = HEAD;
    owner_type = type_of(bus.flit_type_i, owner);

    unique case (state)
      IDLE: begin
        // Scan from rr_ptr upward with wrap; body/tail flits here are stray and only flag an error.
        for (int i = 0; i < N_INPUTS; i++) begin
          scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
          if (scan_sum >= (IDX_W+1)'(N_INPUTS))
            scan_sum = scan_sum - (IDX_W+1)'(N_INPUTS);
          scan_idx  = scan_sum[IDX_W-1:0];
          scan_type = type_of(bus.flit_type_i, scan_idx);
          if (bus.req_i[scan_idx]) begin
            if (scan_type == BODY || scan_type == TAIL) begin
              next_err = 1'b1;
            end else if (!found) begin
              found  = 1'b1;
              winner = scan_idx;
            end
          end
        end

        sel = winner;
        if (found) begin
          grant[winner] = 1'b1;
          if (bus.out_ready_i) begin
            if (type_of(bus.flit_type_i, winner) == HEAD) begin
              next_state = LOCKED;
              next_owner = winner;
            end else begin
              next_rr = incr(winner);
            end
          end
        end
      end

      LOCKED: begin
        sel = owner;
        // A head from the current owner mid-packet is refused rather than forwarded.
        if (bus.req_i[owner]) begin
          if (owner_type == HEAD || owner_type == HEAD_TAIL) begin
            next_err = 1'b1;
          end else begin
            grant[owner] = 1'b1;
            if (bus.out_ready_i && owner_type == TAIL) begin
              next_state = IDLE;
              next_rr    = incr(owner);
            end
          end
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign bus.grant_o  = arst ? grant : '0;
  assign bus.sel_o    = arst ? sel : '0;
  assign bus.valid_o  = |(bus.grant_o & bus.req_i);
  assign bus.locked_o = (state == LOCKED);
  assign bus.err_o    = err_q;

endmodule

// File: tb/tb_ravenoc_wh_arbiter.sv
// Directed scoreboard bench for the wormhole arbiter: each stimulus cycle queues
// its hand-computed expected outputs, a negedge monitor pops and compares them.
module tb_ravenoc_wh_arbiter;

  localparam logic [1:0] H  = 2'd0;
  localparam logic [1:0] B  = 2'd1;
  localparam logic [1:0] T  = 2'd2;
  localparam logic [1:0] HT = 2'd3;

  typedef struct {
    int         tag;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       locked;
    logic       err;
  } exp_t;

  logic clk;
  logic arst;
  exp_t exp_q[$];
  exp_t mon_e;
  int   assert_count;
  int   fail_count;
  int   cycle_tag;

  ravenoc_wh_arbiter_if #(.N_INPUTS(4)) bus ();

  ravenoc_wh_arbiter #(.N_INPUTS(4)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst_v, input logic [3:0] req,
                               input logic [7:0] ft, input logic rdy,
                               input logic [3:0] g, input logic [1:0] s,
                               input logic v, input logic l, input logic e);
    exp_t x;
    @(posedge clk);
    #1;
    arst            = rst_v;
    bus.req_i       = req;
    bus.flit_type_i = ft;
    bus.out_ready_i = rdy;
    cycle_tag++;
    x.tag    = cycle_tag;
    x.grant  = g;
    x.sel    = s;
    x.valid  = v;
    x.locked = l;
    x.err    = e;
    exp_q.push_back(x);
  endtask

  task automatic checkOutput(input exp_t x);
    assert_count++;
    if (bus.grant_o !== x.grant || bus.sel_o !== x.sel || bus.valid_o !== x.valid ||
        bus.locked_o !== x.locked || bus.err_o !== x.err) begin
      fail_count++;
      $display("[TB] FAIL cycle_%0d: got grant=%b sel=%0d valid=%b locked=%b err=%b, expected grant=%b sel=%0d valid=%b locked=%b err=%b",
               x.tag, bus.grant_o, bus.sel_o, bus.valid_o, bus.locked_o, bus.err_o,
               x.grant, x.sel, x.valid, x.locked, x.err);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput(mon_e);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    assert_count    = 0;
    fail_count      = 0;
    cycle_tag       = 0;
    arst            = 1'b0;
    bus.req_i       = '0;
    bus.flit_type_i = '0;
    bus.out_ready_i = 1'b0;

    // Reset state
    applyStimulus(0, 4'b0000, {H,H,H,H}, 0, 4'b0000, 2'd0, 0, 0, 0);

    // Fairness: everyone sends single-flit packets
    applyStimulus(1, 4'b1111, {HT,HT,HT,HT}, 1, 4'b0001, 2'd0, 1, 0, 0);
    applyStimulus(1, 4'b1111, {HT,HT,HT,HT}, 1, 4'b0010, 2'd1, 1, 0, 0);
    applyStimulus(1, 4'b1111, {HT,HT,HT,HT}, 1, 4'b0100, 2'd2, 1, 0, 0);
    applyStimulus(1, 4'b1111, {HT,HT,HT,HT}, 1, 4'b1000, 2'd3, 1, 0, 0);
    applyStimulus(1, 4'b1111, {HT,HT,HT,HT}, 1, 4'b0001, 2'd0, 1, 0, 0);

    // Move pointer to 3, then wrap-around and single repeated requester
    applyStimulus(1, 4'b0100, {H,HT,H,H}, 1, 4'b0100, 2'd2, 1, 0, 0);
    applyStimulus(1, 4'b1000, {HT,H,H,H}, 1, 4'b1000, 2'd3, 1, 0, 0);
    applyStimulus(1, 4'b1000, {HT,H,H,H}, 1, 4'b1000, 2'd3, 1, 0, 0);
    applyStimulus(1, 4'b0000, {H,H,H,H}, 1, 4'b0000, 2'd0, 0, 0, 0);

    // Wormhole lock on input 2 while input 0 waits
    applyStimulus(1, 4'b0001, {H,H,H,HT}, 1, 4'b0001, 2'd0, 1, 0, 0);
    applyStimulus(1, 4'b0101, {H,H,H,HT}, 1, 4'b0100, 2'd2, 1, 0, 0);
    applyStimulus(1, 4'b0101, {H,B,H,HT}, 1, 4'b0100, 2'd2, 1, 1, 0);
    applyStimulus(1, 4'b0101, {H,B,H,HT}, 1, 4'b0100, 2'd2, 1, 1, 0);
    applyStimulus(1, 4'b0101, {H,T,H,HT}, 1, 4'b0100, 2'd2, 1, 1, 0);
    applyStimulus(1, 4'b0001, {H,H,H,HT}, 1, 4'b0001, 2'd0, 1, 0, 0);

    // Backpressure mid-packet on input 1
    applyStimulus(1, 4'b0010, {H,H,H,H}, 1, 4'b0010, 2'd1, 1, 0, 0);
    applyStimulus(1, 4'b0010, {H,H,B,H}, 0, 4'b0010, 2'd1, 1, 1, 0);
    applyStimulus(1, 4'b0010, {H,H,B,H}, 0, 4'b0010, 2'd1, 1, 1, 0);
    applyStimulus(1, 4'b0010, {H,H,B,H}, 0, 4'b0010, 2'd1, 1, 1, 0);
    applyStimulus(1, 4'b0010, {H,H,B,H}, 1, 4'b0010, 2'd1, 1, 1, 0);
    applyStimulus(1, 4'b0010, {H,H,T,H}, 1, 4'b0010, 2'd1, 1, 1, 0);

    // Lock input 1, owner drops request, then reset mid-packet
    applyStimulus(1, 4'b0010, {H,H,H,H}, 1, 4'b0010, 2'd1, 1, 0, 0);
    applyStimulus(1, 4'b0000, {H,H,H,H}, 1, 4'b0000, 2'd1, 0, 1, 0);
    applyStimulus(0, 4'b0010, {H,H,B,H}, 1, 4'b0000, 2'd0, 0, 0, 0);
    applyStimulus(0, 4'b0010, {H,H,B,H}, 1, 4'b0000, 2'd0, 0, 0, 0);
    applyStimulus(1, 4'b0010, {H,H,B,H}, 1, 4'b0000, 2'd0, 0, 0, 0);
    applyStimulus(1, 4'b0000, {H,H,H,H}, 1, 4'b0000, 2'd0, 0, 0, 1);

    // Stray body on input 3 in IDLE, then input 0 proceeds normally
    applyStimulus(1, 4'b1000, {B,H,H,H}, 1, 4'b0000, 2'd0, 0, 0, 0);
    applyStimulus(1, 4'b1001, {B,H,H,H}, 1, 4'b0001, 2'd0, 1, 0, 1);
    applyStimulus(1, 4'b0001, {H,H,H,HT}, 1, 4'b0000, 2'd0, 0, 1, 1);
    applyStimulus(1, 4'b0001, {H,H,H,T}, 1, 4'b0001, 2'd0, 1, 1, 1);
    applyStimulus(1, 4'b0000, {H,H,H,H}, 1, 4'b0000, 2'd1, 0, 0, 0);

    @(posedge clk);
    @(posedge clk);
    #1;
    assert_count++;
    if (exp_q.size() != 0) begin
      fail_count++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
